// File: rtl/dmem_lowx_bridge.sv
// dmem_lowx_bridge: serialises lowX line/uncached requests into XLEN beats.
// Optional per-beat response timeout: define DMEM_LOWX_BRIDGE_TIMEOUT_EN.
module dmem_lowx_bridge #(
   parameter int XLEN           = 32,
   parameter int BLK_SIZE       = 128,
   parameter int ADDR_W         = 32,
   parameter int ID_W           = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic                req_rw_i,
   input  logic                req_uncached_i,
   input  logic [XLEN/8-1:0]   req_wstrb_i,
   input  logic [BLK_SIZE-1:0] req_data_i,
   input  logic [ID_W-1:0]     req_id_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [BLK_SIZE-1:0] res_data_o,
   output logic [ID_W-1:0]     res_id_o,
   output logic                res_err_o,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [XLEN-1:0]     mem_wdata_o,
   output logic [XLEN/8-1:0]   mem_wstrb_o,
   input  logic                mem_rvalid_i,
   input  logic [XLEN-1:0]     mem_rdata_i,
   input  logic                mem_err_i
);

   localparam int NBEATS = BLK_SIZE / XLEN;
   localparam int IDX_W  = $clog2(NBEATS);
   localparam int SB     = XLEN / 8;
   localparam int WOFF_W = $clog2(SB);
   localparam int LOFF_W = $clog2(BLK_SIZE / 8);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                     state_q, state_d;
   logic [ADDR_W-LOFF_W-1:0]   line_q;
   logic                       rw_q;
   logic                       unc_q;
   logic [SB-1:0]              wstrb_q;
   logic [BLK_SIZE-1:0]        wdata_q;
   logic [BLK_SIZE-1:0]        buf_q;
   logic [ID_W-1:0]            id_q;
   logic [IDX_W-1:0]           idx_q;
   logic                       err_q;
   logic                       last;
   logic                       tmo_hit;
   logic                       unused_addr;

   assign last        = unc_q || (idx_q == IDX_W'(NBEATS - 1));
   assign unused_addr = ^req_addr_i[WOFF_W-1:0];

`ifdef DMEM_LOWX_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q;

   assign tmo_hit = (state_q == WAIT) && !mem_rvalid_i &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else if (state_q != WAIT) begin
         tmo_q <= '0;
      end else if (!mem_rvalid_i) begin
         tmo_q <= tmo_q + 1'b1;
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES != 0);
   assign tmo_hit    = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      req_ready_o     = 1'b0;
      res_valid_o     = 1'b0;
      res_data_o      = '0;
      res_id_o        = '0;
      res_err_o       = 1'b0;
      mem_req_valid_o = 1'b0;
      mem_addr_o      = '0;
      mem_we_o        = 1'b0;
      mem_wdata_o     = '0;
      mem_wstrb_o     = '0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = ISSUE;
         end
         ISSUE: begin
            mem_req_valid_o = 1'b1;
            // base + 4*idx; for uncached idx is the word offset itself
            mem_addr_o      = {line_q, idx_q, WOFF_W'(0)};
            mem_we_o        = rw_q;
            mem_wdata_o     = wdata_q[idx_q*XLEN +: XLEN];
            mem_wstrb_o     = !rw_q ? '0 : (unc_q ? wstrb_q : '1);
            if (mem_req_ready_i) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid_i) state_d = (mem_err_i || last) ? RESP : ISSUE;
            else if (tmo_hit) state_d = RESP;
         end
         RESP: begin
            res_valid_o = 1'b1;
            res_data_o  = buf_q;
            res_id_o    = id_q;
            res_err_o   = err_q;
            if (res_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q  <= '0;
         rw_q    <= 1'b0;
         unc_q   <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         id_q    <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid_i) begin
               line_q  <= req_addr_i[ADDR_W-1:LOFF_W];
               rw_q    <= req_rw_i;
               unc_q   <= req_uncached_i;
               wstrb_q <= req_wstrb_i;
               wdata_q <= req_data_i;
               id_q    <= req_id_i;
               buf_q   <= '0;
               err_q   <= 1'b0;
               idx_q   <= req_uncached_i ?
                          req_addr_i[LOFF_W-1:WOFF_W] : '0;
            end
            WAIT: begin
               if (mem_rvalid_i) begin
                  if (!rw_q) buf_q[idx_q*XLEN +: XLEN] <= mem_rdata_i;
                  if (mem_err_i)  err_q <= 1'b1;
                  else if (!last) idx_q <= idx_q + 1'b1;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lowx_bridge.sv
// Directed vector bench for dmem_lowx_bridge with a zero-wait memory model.
// Stall, error and mid-transaction reset cases use the same memory model.
module tb_dmem_lowx_bridge;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [31:0]  req_addr_i;
   logic         req_rw_i;
   logic         req_uncached_i;
   logic [3:0]   req_wstrb_i;
   logic [127:0] req_data_i;
   logic [3:0]   req_id_i;
   logic         res_valid_o;
   logic         res_ready_i;
   logic [127:0] res_data_o;
   logic [3:0]   res_id_o;
   logic         res_err_o;
   logic         mem_req_valid_o;
   logic         mem_req_ready_i;
   logic [31:0]  mem_addr_o;
   logic         mem_we_o;
   logic [31:0]  mem_wdata_o;
   logic [3:0]   mem_wstrb_o;
   logic         mem_rvalid_i;
   logic [31:0]  mem_rdata_i;
   logic         mem_err_i;

   dmem_lowx_bridge dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_rw_i(req_rw_i),
      .req_uncached_i(req_uncached_i), .req_wstrb_i(req_wstrb_i),
      .req_data_i(req_data_i), .req_id_i(req_id_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_data_o(res_data_o), .res_id_o(res_id_o), .res_err_o(res_err_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .mem_err_i(mem_err_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0]       addr;
      logic              rw;
      logic              unc;
      logic [3:0]        wstrb;
      logic [127:0]      data;
      logic [3:0]        id;
      logic [3:0][31:0]  rd;
      int                err_beat;
      int                stall;
      int                hold;
      int                nbeats;
      logic [3:0][31:0]  ea;
      logic [3:0][31:0]  ewd;
      logic [3:0]        ews;
      logic              ewe;
      logic [127:0]      eres;
      logic              eerr;
      int                elat;
   } vec_t;

   int nvec = 0;
   int nmis = 0;

   // memory model state
   int               nbeat = 0;
   int               rsp_n = 0;
   int               err_beat = -1;
   int               stall_beat = 2;
   int               stall_left = 0;
   bit               pend = 0;
   bit               mute = 0;
   bit               snap_valid = 0;
   bit               stab_bad = 0;
   logic [68:0]      snap;
   logic [3:0][31:0] cur_rd;
   logic [68:0]      blog [8];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      mem_req_ready_i = 1'b1;
      mem_rvalid_i    = 1'b0;
      mem_rdata_i     = '0;
      mem_err_i       = 1'b0;
      forever begin
         @(negedge clk_i);
         if (mem_req_valid_o && mem_req_ready_i) begin
            if (nbeat < 8)
               blog[nbeat] = {mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o};
            nbeat++;
            pend = 1;
         end else if (mem_req_valid_o && stall_left > 0 &&
                      nbeat == stall_beat) begin
            if (!snap_valid) begin
               snap = {mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o};
               snap_valid = 1;
            end else if (snap !== {mem_addr_o, mem_we_o,
                                   mem_wdata_o, mem_wstrb_o}) begin
               stab_bad = 1;
            end
            stall_left--;
         end
         @(posedge clk_i);
         #1;
         mem_rvalid_i = 1'b0;
         mem_err_i    = 1'b0;
         mem_rdata_i  = '0;
         if (pend && !mute && rsp_n < 4) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = cur_rd[rsp_n];
            mem_err_i    = (rsp_n == err_beat);
            rsp_n++;
         end
         pend = 0;
         mem_req_ready_i = !(stall_left > 0 && nbeat == stall_beat);
      end
   end

   function automatic vec_t mk(input logic [31:0] a, input logic rw,
                               input logic unc, input logic [3:0] id);
      vec_t v;
      v = '0;
      v.addr = a; v.rw = rw; v.unc = unc; v.id = id;
      v.err_beat = -1; v.nbeats = unc ? 1 : 4; v.ewe = rw;
      v.ews = rw ? 4'hF : 4'h0;
      v.elat = unc ? 2 : 8;
      return v;
   endfunction

   task automatic arm_mem(input vec_t v);
      nbeat = 0; rsp_n = 0; cur_rd = v.rd; err_beat = v.err_beat;
      stall_left = v.stall; snap_valid = 0; stab_bad = 0;
   endtask

   task automatic send_req(input vec_t v, input string nm);
      req_addr_i = v.addr; req_rw_i = v.rw; req_uncached_i = v.unc;
      req_wstrb_i = v.wstrb; req_data_i = v.data; req_id_i = v.id;
      req_valid_i = 1'b1;
      chk({nm, "_req_ready"}, {127'd0, req_ready_o}, 128'd1);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int lat;
      bit bad;
      string nm;
      nm = $sformatf("v%0d", k);
      arm_mem(v);
      send_req(v, nm);
      lat = 0;
      while (!res_valid_o && lat < 200) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      chk({nm, "_latency"}, 128'(lat), 128'(v.elat));
      chk({nm, "_res_valid"}, {127'd0, res_valid_o}, 128'd1);
      chk({nm, "_res_data"}, res_data_o, v.eres);
      chk({nm, "_res_id_err"}, {123'd0, res_id_o, res_err_o},
          {123'd0, v.id, v.eerr});
      chk({nm, "_busy_ready"}, {127'd0, req_ready_o}, 128'd0);
      bad = 0;
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk_i);
         #1;
         if (res_valid_o !== 1'b1 || res_data_o !== v.eres ||
             res_id_o !== v.id || res_err_o !== v.eerr ||
             req_ready_o !== 1'b0)
            bad = 1;
      end
      if (v.hold > 0) chk({nm, "_res_stable"}, {127'd0, bad}, 128'd0);
      res_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      res_ready_i = 1'b0;
      chk({nm, "_idle"}, {126'd0, req_ready_o, res_valid_o}, 128'd2);
      chk({nm, "_nbeats"}, 128'(nbeat), 128'(v.nbeats));
      for (int b = 0; b < v.nbeats && b < 8; b++)
         chk($sformatf("%s_beat%0d", nm, b), {59'd0, blog[b]},
             {59'd0, v.ea[b], v.ewe, v.ewd[b], v.ews});
      if (v.stall > 0)
         chk({nm, "_bus_stable"}, {127'd0, stab_bad}, 128'd0);
   endtask

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(32'h8000_0014, 1'b0, 1'b0, 4'd3);
      vecs[0].rd   = {32'h44, 32'h33, 32'h22, 32'h11};
      vecs[0].ea   = {32'h8000_001C, 32'h8000_0018,
                      32'h8000_0014, 32'h8000_0010};
      vecs[0].eres = 128'h00000044_00000033_00000022_00000011;

      vecs[1] = mk(32'h8000_0040, 1'b1, 1'b0, 4'd5);
      vecs[1].data = {32'hDDDD_DDDD, 32'hCCCC_CCCC,
                      32'hBBBB_BBBB, 32'hAAAA_AAAA};
      vecs[1].ewd  = vecs[1].data;
      vecs[1].ea   = {32'h8000_004C, 32'h8000_0048,
                      32'h8000_0044, 32'h8000_0040};

      vecs[2] = mk(32'h2000_0006, 1'b1, 1'b1, 4'd9);
      vecs[2].wstrb = 4'hC;
      vecs[2].data  = {32'h0, 32'h0, 32'h1234_0000, 32'h0};
      vecs[2].ea[0] = 32'h2000_0004;
      vecs[2].ewd[0] = 32'h1234_0000;
      vecs[2].ews   = 4'hC;

      vecs[3] = mk(32'h1000_0008, 1'b0, 1'b1, 4'd7);
      vecs[3].rd[0] = 32'hCAFE_BABE;
      vecs[3].ea[0] = 32'h1000_0008;
      vecs[3].eres  = {32'h0, 32'hCAFE_BABE, 32'h0, 32'h0};

      vecs[4] = mk(32'h0000_0100, 1'b0, 1'b0, 4'd2);
      vecs[4].rd = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
      vecs[4].err_beat = 1;
      vecs[4].nbeats = 2;
      vecs[4].ea = {32'h0, 32'h0, 32'h104, 32'h100};
      vecs[4].eres = {32'h0, 32'h0, 32'hA2, 32'hA1};
      vecs[4].eerr = 1'b1;
      vecs[4].elat = 4;

      vecs[5] = mk(32'h0000_0100, 1'b0, 1'b0, 4'hF);
      vecs[5].rd = {32'hD4, 32'hD3, 32'hD2, 32'hD1};
      vecs[5].ea = {32'h10C, 32'h108, 32'h104, 32'h100};
      vecs[5].eres = {32'hD4, 32'hD3, 32'hD2, 32'hD1};

      vecs[6] = mk(32'h4000_0030, 1'b0, 1'b0, 4'd6);
      vecs[6].rd = {32'h5EED_0004, 32'h5EED_0003,
                    32'h5EED_0002, 32'h5EED_0001};
      vecs[6].ea = {32'h4000_003C, 32'h4000_0038,
                    32'h4000_0034, 32'h4000_0030};
      vecs[6].eres = {32'h5EED_0004, 32'h5EED_0003,
                      32'h5EED_0002, 32'h5EED_0001};
      vecs[6].stall = 5;
      vecs[6].hold = 3;
      vecs[6].elat = 13;

      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_addr_i = '0; req_rw_i = 1'b0;
      req_uncached_i = 1'b0; req_wstrb_i = '0; req_data_i = '0;
      req_id_i = '0; res_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_outputs",
          {res_data_o, res_id_o, res_err_o, res_valid_o, req_ready_o,
           mem_req_valid_o, mem_we_o, mem_wstrb_o},
          {128'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
      chk("reset_bus", {64'd0, mem_addr_o, mem_wdata_o}, 128'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

      // abort a read while waiting on a silent memory
      begin
         int n;
         mute = 1;
         arm_mem(vecs[0]);
         send_req(vecs[0], "rst");
         n = 0;
         while (nbeat < 1 && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
         end
         chk("rst_in_wait", 128'(nbeat), 128'd1);
         #3;
         rst_ni = 1'b0;
         #1;
         chk("rst_async",
             {res_data_o, res_id_o, res_err_o, res_valid_o, req_ready_o,
              mem_req_valid_o, mem_we_o, mem_wstrb_o},
             {128'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
         @(negedge clk_i);
         rst_ni = 1'b1;
         mute = 0;
         n = 0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            if (res_valid_o || mem_req_valid_o || !req_ready_o) n++;
         end
         chk("rst_no_resp", 128'(n), 128'd0);
         run_vec(vecs[0], 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/dmem_lowx_bridge.md
Name: dmem_lowx_bridge

Overview:
- Sits directly downstream of the memory stage's data cache and consumes its lowX request.
- Serialises each cache-line request (refill or writeback) or uncached single-word access into XLEN-wide beats on a simple valid/ready memory bus.
- Reassembles read beats into a line and returns a single lowX response carrying the original request ID.
- One lowX transaction in flight; one bus beat outstanding at a time.

Parameters:
- XLEN, 32, data beat width in bits
- BLK_SIZE, 128, cache line width in bits; BLK_SIZE/XLEN = NBEATS (power of 2, ≥2)
- ADDR_W, 32, address width
- ID_W, 4, lowX request ID width
- TIMEOUT_CYCLES, 1024, per-beat response timeout; used only with the optional feature

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  lowX request valid
- req_ready_o  out  1  bridge can accept a request
- req_addr_i  in  ADDR_W  byte address
- req_rw_i  in  1  1 = write, 0 = read
- req_uncached_i  in  1  single-word access
- req_wstrb_i  in  XLEN/8  byte strobe for uncached writes
- req_data_i  in  BLK_SIZE  write line
- req_id_i  in  ID_W  request ID
- res_valid_o  out  1  response valid
- res_ready_i  in  1  response accepted
- res_data_o  out  BLK_SIZE  read line; zero for writes
- res_id_o  out  ID_W  echoed ID
- res_err_o  out  1  bus error (or timeout) occurred
- mem_req_valid_o  out  1  beat request valid
- mem_req_ready_i  in  1  memory accepts beat
- mem_addr_o  out  ADDR_W  beat address, word aligned
- mem_we_o  out  1  beat is a write
- mem_wdata_o  out  XLEN  write beat data
- mem_wstrb_o  out  XLEN/8  write beat strobe
- mem_rvalid_i  in  1  beat response (read data or write ack)
- mem_rdata_i  in  XLEN  read beat data
- mem_err_i  in  1  beat error, qualified by mem_rvalid_i

Behaviour:
- Reset:
  - State IDLE; all outputs 0 except req_ready_o = 1.
  - Line buffer, beat counter, error flag and ID all cleared.
  - Reset asserted mid-transaction aborts it immediately; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i: latch addr, rw, uncached, data, wstrb and id; clear the line buffer and error flag; go to ISSUE.
- Beat setup:
  - Cached: base = req_addr_i with its low log2(BLK_SIZE/8) bits cleared; beat index starts at 0; NBEATS beats.
  - Uncached: beat index = req_addr_i word offset within the line; exactly 1 beat.
- ISSUE:
  - mem_req_valid_o = 1; mem_addr_o = base + 4·index, or the word-aligned request address for uncached.
  - mem_we_o = rw; mem_wdata_o = latched line lane[index].
  - mem_wstrb_o = all ones for cached, latched wstrb for uncached; 0 for reads.
  - All bus outputs held stable until mem_req_ready_i; on handshake go to WAIT.
- WAIT:
  - On mem_rvalid_i: for reads, write mem_rdata_i into line lane[index]; for writes, data is ignored.
  - If mem_err_i: set error flag, go to RESP (remaining beats abandoned).
  - Else if last beat: go to RESP.
  - Else: index+1, go to ISSUE.
  - mem_rvalid_i outside WAIT is ignored.
- RESP:
  - res_valid_o = 1 with res_data_o = line buffer; uncached read data sits only in lane[word offset], other lanes 0.
  - res_id_o = latched id; res_err_o = error flag.
  - Response held stable until res_ready_i; then go to IDLE. req_ready_o is 0 in RESP.
- Latency, zero-wait memory (ready immediate, rvalid the cycle after accept):
  - Request accepted at cycle T → res_valid_o at T + 2·NBEATS + 1.
  - Cached, NBEATS = 4 → T+9; uncached → T+3.
- Back-to-back: a new request is accepted only in IDLE, at the earliest the cycle after the response handshake.

Optional Feature:
- Macro DMEM_LOWX_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without mem_rvalid_i.
  - On reaching TIMEOUT_CYCLES: set error flag, go to RESP.
  - A late mem_rvalid_i after that point is ignored.
- Undefined: no counter; WAIT holds indefinitely.

Test Plan:
- Cached read at 0x8000_0014, id 3, zero-wait memory returning 0x11,0x22,0x33,0x44 → mem_addr_o sequence 0x8000_0010/14/18/1C; res_data_o = 0x00000044_00000033_00000022_00000011; res_id_o = 3; res_valid_o at T+9.
- Cached write at 0x8000_0040 with line 0xDDDD…_CCCC…_BBBB…_AAAA… → four beats, we = 1, wstrb = 0xF, wdata order AAAA, BBBB, CCCC, DDDD; res_data_o = 0; res_err_o = 0.
- Uncached write to 0x2000_0006 with wstrb 0xC and data in lane 1 = 0x1234_0000 → one beat, addr 0x2000_0004, wdata 0x1234_0000, wstrb 0xC; response at T+3.
- mem_req_ready_i low for 5 cycles on beat 2, res_ready_i low for 3 cycles → bus outputs and response stable throughout; no extra beats; req_ready_o stays 0 until the response handshake.
- mem_err_i on beat 1 of a 4-beat read → exactly 2 beats issued; res_err_o = 1; next request accepted normally with res_err_o = 0.
- rst_ni pulsed low during WAIT → all outputs at reset values asynchronously; no res_valid_o; a subsequent read completes correctly. With DMEM_LOWX_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 16, silent memory → res_err_o = 1 after 16 WAIT cycles.
